// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer for the 9-bit core: fetch/exec/mem-wait/write-back.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module exec_sequencer #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Branch,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             RegWrite,
    input  logic             BranchTaken,
    output logic             PcClear,
    output logic             IrLoad,
    output logic             PcInc,
    output logic             PcLoad,
    output logic             RegWE,
    output logic             MemRE,
    output logic             MemWE,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrCnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEMW  = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_e     state_q, state_d;
    logic       armed_q, armed_d;
    logic [2:0] lat_q, lat_d;
    logic       retire;

    logic is_load;
    assign is_load = MemRead & ~MemWrite;

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        lat_d   = lat_q;
        retire  = 1'b0;
        PcClear = 1'b0;
        IrLoad  = 1'b0;
        PcInc   = 1'b0;
        PcLoad  = 1'b0;
        RegWE   = 1'b0;
        MemRE   = 1'b0;
        MemWE   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (armed_q) begin
                    state_d = S_FETCH;
                    armed_d = 1'b0;
                end
            end
            S_FETCH: begin
                IrLoad  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (Halt) begin
                    state_d = S_DONE;
                end else if (is_load) begin
                    MemRE   = 1'b1;
                    lat_d   = LAT_INIT;
                    state_d = S_MEMW;
                end else if (MemWrite) begin
                    MemWE   = 1'b1;
                    PcInc   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (Branch) begin
                    PcLoad  = BranchTaken;
                    PcInc   = ~BranchTaken;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    RegWE   = RegWrite;
                    PcInc   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMW: begin
                MemRE = 1'b1;
                if (lat_q == 3'd0) begin
                    state_d = S_WB;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_WB: begin
                RegWE   = 1'b1;
                PcInc   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Start aborts whatever is in flight; only the PC clear survives.
        if (Start) begin
            state_d = S_IDLE;
            armed_d = 1'b1;
            lat_d   = 3'd0;
            retire  = 1'b0;
            PcClear = Reset_n;
            IrLoad  = 1'b0;
            PcInc   = 1'b0;
            PcLoad  = 1'b0;
            RegWE   = 1'b0;
            MemRE   = 1'b0;
            MemWE   = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            lat_q   <= lat_d;
        end
    end

    assign Busy = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                  (state_q == S_MEMW)  || (state_q == S_WB);
    assign Done = (state_q == S_DONE);

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ins_q, ins_d;

    always_comb begin
        cyc_d = cyc_q;
        ins_d = ins_q;
        if (Start) begin
            cyc_d = '0;
            ins_d = '0;
        end else begin
            if (Busy && (cyc_q != '1)) begin
                cyc_d = cyc_q + 1'b1;
            end
            if (retire && (ins_q != '1)) begin
                ins_d = ins_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign CycleCnt = cyc_q;
    assign InstrCnt = ins_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign CycleCnt      = '0;
    assign InstrCnt      = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: per-cycle strobe scoreboard plus
// counter checks at the end of each program.
module tb_exec_sequencer;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned CNT_W   = 16;

    // strobe vector {PcClear,IrLoad,PcInc,PcLoad,RegWE,MemRE,MemWE,Busy,Done}
    localparam logic [8:0] PCC = 9'h100;
    localparam logic [8:0] IRL = 9'h080;
    localparam logic [8:0] PCI = 9'h040;
    localparam logic [8:0] PCL = 9'h020;
    localparam logic [8:0] RWE = 9'h010;
    localparam logic [8:0] MRE = 9'h008;
    localparam logic [8:0] MWE = 9'h004;
    localparam logic [8:0] BSY = 9'h002;
    localparam logic [8:0] DN  = 9'h001;

    // instruction flags {Halt,Branch,MemRead,MemWrite,RegWrite,BranchTaken}
    localparam logic [5:0] I_NONE  = 6'b000000;
    localparam logic [5:0] I_ADD   = 6'b000010;
    localparam logic [5:0] I_HALT  = 6'b100000;
    localparam logic [5:0] I_LOAD  = 6'b001010;
    localparam logic [5:0] I_STORE = 6'b001100;
    localparam logic [5:0] I_BEQT  = 6'b010001;
    localparam logic [5:0] I_BEQN  = 6'b010000;

    logic Clk = 1'b0;
    logic Reset_n, Start, Halt, Branch, MemRead, MemWrite, RegWrite, BranchTaken;
    logic PcClear, IrLoad, PcInc, PcLoad, RegWE, MemRE, MemWE, Busy, Done;
    logic [CNT_W-1:0] CycleCnt, InstrCnt;

    exec_sequencer #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
        .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .BranchTaken(BranchTaken),
        .PcClear(PcClear), .IrLoad(IrLoad), .PcInc(PcInc), .PcLoad(PcLoad),
        .RegWE(RegWE), .MemRE(MemRE), .MemWE(MemWE), .Busy(Busy),
        .Done(Done), .CycleCnt(CycleCnt), .InstrCnt(InstrCnt)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        string      tag;
        logic [8:0] vec;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk_vec(input string tag, input logic [8:0] e);
        logic [8:0] o;
        o = {PcClear, IrLoad, PcInc, PcLoad, RegWE, MemRE, MemWE, Busy, Done};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk_cnt(input string tag, input int c, input int i);
        logic [CNT_W-1:0] ec, ei;
        ec = CNT_W'(c);
        ei = CNT_W'(i);
`ifndef SEQ_PERF_CNT_EN
        ec = '0;
        ei = '0;
`endif
        checks++;
        assert (CycleCnt === ec) else begin
            errors++;
            $error("FAIL %s.cyc observed=%0d expected=%0d", tag, CycleCnt, ec);
        end
        checks++;
        assert (InstrCnt === ei) else begin
            errors++;
            $error("FAIL %s.ins observed=%0d expected=%0d", tag, InstrCnt, ei);
        end
    endtask

    // drive one cycle after the edge, check its strobes at the falling edge
    task automatic cyc(input logic st, input logic [5:0] ins,
                       input logic [8:0] e, input string tag);
        exp_t x;
        @(posedge Clk);
        #1;
        Start = st;
        {Halt, Branch, MemRead, MemWrite, RegWrite, BranchTaken} = ins;
        x.tag = tag;
        x.vec = e;
        sb.push_back(x);
        #4;
        x = sb.pop_front();
        chk_vec(x.tag, x.vec);
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b0;
        {Halt, Branch, MemRead, MemWrite, RegWrite, BranchTaken} = I_NONE;
        #2;
        chk_vec("reset", 9'h000);
        chk_cnt("reset", 0, 0);
        #10;
        Reset_n = 1'b1;

        for (int k = 0; k < 10; k++) cyc(1'b0, I_NONE, 9'h000, "idle_nostart");

        // add, add, halt
        cyc(1'b1, I_NONE, PCC, "p1_start0");
        cyc(1'b1, I_NONE, PCC, "p1_start1");
        cyc(1'b0, I_NONE, 9'h000, "p1_c0");
        cyc(1'b0, I_ADD, IRL | BSY, "p1_c1_fetch");
        cyc(1'b0, I_ADD, PCI | RWE | BSY, "p1_c2_add");
        cyc(1'b0, I_ADD, IRL | BSY, "p1_c3_fetch");
        cyc(1'b0, I_ADD, PCI | RWE | BSY, "p1_c4_add");
        cyc(1'b0, I_HALT, IRL | BSY, "p1_c5_fetch");
        cyc(1'b0, I_HALT, BSY, "p1_c6_halt");
        cyc(1'b0, I_HALT, DN, "p1_c7_done");
        chk_cnt("p1", 6, 2);

        // load then halt
        cyc(1'b1, I_NONE, PCC | DN, "p2_start");
        cyc(1'b0, I_NONE, 9'h000, "p2_idle");
        cyc(1'b0, I_LOAD, IRL | BSY, "p2_fetch");
        cyc(1'b0, I_LOAD, MRE | BSY, "p2_exec");
        cyc(1'b0, I_LOAD, MRE | BSY, "p2_memw0");
        cyc(1'b0, I_LOAD, MRE | BSY, "p2_memw1");
        cyc(1'b0, I_LOAD, RWE | PCI | BSY, "p2_wb");
        cyc(1'b0, I_HALT, IRL | BSY, "p2_fetch_h");
        cyc(1'b0, I_HALT, BSY, "p2_halt");
        cyc(1'b0, I_HALT, DN, "p2_done");
        cyc(1'b0, I_NONE, DN, "p2_done_hold");
        chk_cnt("p2", 7, 1);

        // store then halt
        cyc(1'b1, I_NONE, PCC | DN, "p3_start");
        cyc(1'b0, I_NONE, 9'h000, "p3_idle");
        cyc(1'b0, I_STORE, IRL | BSY, "p3_fetch");
        cyc(1'b0, I_STORE, MWE | PCI | BSY, "p3_store");
        cyc(1'b0, I_HALT, IRL | BSY, "p3_fetch_h");
        cyc(1'b0, I_HALT, BSY, "p3_halt");
        cyc(1'b0, I_HALT, DN, "p3_done");
        chk_cnt("p3", 4, 1);

        // taken branch, not-taken branch, halt
        cyc(1'b1, I_NONE, PCC | DN, "p4_start");
        cyc(1'b0, I_NONE, 9'h000, "p4_idle");
        cyc(1'b0, I_BEQT, IRL | BSY, "p4_fetch0");
        cyc(1'b0, I_BEQT, PCL | BSY, "p4_taken");
        cyc(1'b0, I_BEQN, IRL | BSY, "p4_fetch1");
        cyc(1'b0, I_BEQN, PCI | BSY, "p4_nottaken");
        cyc(1'b0, I_HALT, IRL | BSY, "p4_fetch_h");
        cyc(1'b0, I_HALT, BSY, "p4_halt");
        cyc(1'b0, I_HALT, DN, "p4_done");
        chk_cnt("p4", 6, 2);

        // Start aborts a load in MEMW
        cyc(1'b1, I_NONE, PCC | DN, "p5_start");
        cyc(1'b0, I_NONE, 9'h000, "p5_idle");
        cyc(1'b0, I_LOAD, IRL | BSY, "p5_fetch");
        cyc(1'b0, I_LOAD, MRE | BSY, "p5_exec");
        cyc(1'b1, I_LOAD, PCC | BSY, "p5_abort_memw");
        cyc(1'b0, I_LOAD, 9'h000, "p5_after_abort");
        chk_cnt("p5_abort", 0, 0);

        // restarted load, reset pulse during WB
        cyc(1'b0, I_LOAD, IRL | BSY, "p6_fetch");
        cyc(1'b0, I_LOAD, MRE | BSY, "p6_exec");
        cyc(1'b0, I_LOAD, MRE | BSY, "p6_memw0");
        cyc(1'b0, I_LOAD, MRE | BSY, "p6_memw1");
        cyc(1'b0, I_LOAD, RWE | PCI | BSY, "p6_wb");
        Reset_n = 1'b0;
        #1;
        chk_vec("p6_async_reset", 9'h000);
        chk_cnt("p6_async_reset", 0, 0);
        #1;
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc(1'b0, I_LOAD, 9'h000, "p6_post_reset");
        chk_cnt("p6_post_reset", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Multi-cycle sequencing controller for the 9-bit core: walks each instruction through fetch, execute, data-memory wait and write-back, and gates the decoder's static control lines into single-cycle strobes. Sits between the opcode decoder and the PC, instruction register, register file and data memory. Owns the Start/Done program handshake and the optional performance counters.

## Interface
- MEM_LAT, 2, data-memory read latency in cycles (legal 1..7)
- CNT_W, 16, width of the performance counters
- Clk  in  1  clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  program request from the test bench; level-sensitive
- Halt  in  1  current instruction is the program-end marker (decoded)
- Branch  in  1  decoder branch flag
- MemRead  in  1  decoder memory-read flag
- MemWrite  in  1  decoder memory-write flag
- RegWrite  in  1  decoder register-write flag
- BranchTaken  in  1  ALU equality result for the current instruction
- PcClear  out  1  reset PC to 0
- IrLoad  out  1  latch instruction memory output into IR
- PcInc  out  1  PC <= PC+1
- PcLoad  out  1  PC <= branch target
- RegWE  out  1  register-file write strobe
- MemRE  out  1  data-memory read enable
- MemWE  out  1  data-memory write strobe
- Busy  out  1  program running
- Done  out  1  program finished
- CycleCnt  out  CNT_W  active cycles of the last/current run
- InstrCnt  out  CNT_W  retired instructions of the last/current run

## Operation
- States: IDLE, FETCH, EXEC, MEMW, WB, DONE. Reset (async) -> IDLE, armed flag cleared, counters 0; every output 0.
- Start=1 in any state: next state IDLE, armed<=1, PcClear=1 that cycle, counters cleared. Start dominates all other transitions.
- IDLE: leaves to FETCH only when armed=1 and Start=0; armed clears on exit. Start never seen since reset -> stay IDLE.
- FETCH: IrLoad=1; -> EXEC.
- EXEC (decoder inputs valid): classification in priority order:
  - Halt=1: no strobes; -> DONE.
  - Load = MemRead & ~MemWrite: MemRE=1; -> MEMW, latency counter loaded with MEM_LAT-1.
  - Store = MemWrite: MemWE=1 for exactly this cycle, PcInc=1; -> FETCH. (Decoder also raises MemRead for stores; ignored.)
  - Branch=1: PcLoad=BranchTaken, PcInc=~BranchTaken; -> FETCH.
  - Otherwise: RegWE=RegWrite, PcInc=1; -> FETCH.
- MEMW: MemRE=1; counter decrements; at 0 -> WB. MEM_LAT=1 spends one MEMW cycle.
- WB: RegWE=1, PcInc=1; -> FETCH.
- DONE: Done=1; held until Start=1.
- Busy=1 in FETCH, EXEC, MEMW, WB.
- PcInc and PcLoad are mutually exclusive; RegWE and MemWE never both 1.

## Timing
- Strobes are combinational from state and EXEC-cycle inputs; state, armed flag, latency counter and counters are registered.
- Cycles per instruction: ALU/store/branch 2; load 3+MEM_LAT; halt 2 (FETCH+EXEC) then DONE.
- Done rises the cycle after the halt EXEC; falls the cycle after Start is sampled 1.
- CycleCnt +1 on every cycle with Busy=1; InstrCnt +1 on each exit to FETCH from EXEC or WB (halt not counted). Both saturate at 2^CNT_W-1; values hold in DONE and clear only on Start=1 or reset.
- Reset_n low mid-load: outputs drop to 0 immediately, no pending MemRE/RegWE completes.
- Start=1 mid-instruction: aborts at that edge; any strobe in that cycle is suppressed except PcClear.

## Configuration
- SEQ_PERF_CNT_EN defined: CycleCnt/InstrCnt implemented as above.
- Undefined: counter registers not built; CycleCnt and InstrCnt tied to 0; all other behaviour identical.

## Test plan
- Reset_n low then high, Start=0 for 10 cycles -> stays IDLE, all outputs 0, no IrLoad.
- Start 1 for 2 cycles then 0; program add, add, halt -> PcClear in both Start cycles, IrLoad at cycles 1,3,5 after release, RegWE at 2,4, Done at cycle 7, InstrCnt=2, CycleCnt=6.
- MEM_LAT=2, single load then halt -> MemRE high 3 consecutive cycles, RegWE+PcInc exactly one cycle after, InstrCnt=1, CycleCnt=7.
- Store with MemRead=1, MemWrite=1 -> one-cycle MemWE, MemRE=0, RegWE=0, PcInc=1.
- Branch with BranchTaken=1 then 0 -> PcLoad=1/PcInc=0, then PcLoad=0/PcInc=1.
- Start=1 during MEMW -> next cycle IDLE, MemRE=0, RegWE never asserted, counters 0; Reset_n pulse during WB -> outputs 0 asynchronously.
